// File: rtl/cpu_pkg.sv
// cpu_pkg: step codes and opcodes shared by the sequencer and the bus-control decoder.
// The optional retire counter is controlled by CTRL_RETIRE_CNT_EN in control_sequencer.
package cpu_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'h0,
        ST_ILL    = 4'h1,
        ST_LOAD   = 4'h2,
        ST_MOVE   = 4'h3,
        ST_LDPC   = 4'h4,
        ST_BRANCH = 4'h5,
        ST_SUB0   = 4'h6,
        ST_SUB1   = 4'h7,
        ST_SUB2   = 4'h8,
        ST_ADD0   = 4'h9,
        ST_ADD1   = 4'hA,
        ST_ADD2   = 4'hB,
        ST_XOR0   = 4'hC,
        ST_XOR1   = 4'hD,
        ST_XOR2   = 4'hE
    } step_e;

    localparam logic [3:0] OP_LOAD   = 4'd0;
    localparam logic [3:0] OP_MOVE   = 4'd1;
    localparam logic [3:0] OP_LDPC   = 4'd2;
    localparam logic [3:0] OP_BRANCH = 4'd3;
    localparam logic [3:0] OP_SUB    = 4'd4;
    localparam logic [3:0] OP_ADD    = 4'd5;
    localparam logic [3:0] OP_XOR    = 4'd6;

    function automatic logic is_last_step(input step_e s);
        return s inside {ST_LOAD, ST_MOVE, ST_LDPC, ST_BRANCH, ST_ILL, ST_SUB2, ST_ADD2, ST_XOR2};
    endfunction

endpackage

// File: rtl/seq_first_step.sv
// seq_first_step: maps an opcode to the first step code of its sequence.
module seq_first_step
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output step_e      first_step
);

    always_comb begin
        case (opcode)
            OP_LOAD:   first_step = ST_LOAD;
            OP_MOVE:   first_step = ST_MOVE;
            OP_LDPC:   first_step = ST_LDPC;
            OP_BRANCH: first_step = ST_BRANCH;
            OP_SUB:    first_step = ST_SUB0;
            OP_ADD:    first_step = ST_ADD0;
            OP_XOR:    first_step = ST_XOR0;
            default:   first_step = ST_ILL;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: instruction step sequencer driving the bus-control decoder.
// Define CTRL_RETIRE_CNT_EN to add the retire_cnt output counting legal completions.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        run,
    input  logic [15:0] instr,
    output logic [3:0]  state,
    output logic [15:0] instr_q,
    output logic        busy,
    output logic        done,
    output logic        illegal
`ifdef CTRL_RETIRE_CNT_EN
    ,
    output logic [15:0] retire_cnt
`endif
);

    step_e       state_q, state_d, first_step;
    logic [15:0] instr_d;
    logic        armed_q, accept;

    seq_first_step u_first_step (
        .opcode     (instr[15:12]),
        .first_step (first_step)
    );

    // armed_q blocks acceptance on the first edge after reset is released
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            instr_q <= 16'h0000;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        accept  = armed_q && run && (state_q == ST_IDLE || done);
        state_d = ST_IDLE;
        instr_d = instr_q;
        if (accept) begin
            state_d = first_step;
            instr_d = instr;
        end else begin
            case (state_q)
                ST_SUB0: state_d = ST_SUB1;
                ST_SUB1: state_d = ST_SUB2;
                ST_ADD0: state_d = ST_ADD1;
                ST_ADD1: state_d = ST_ADD2;
                ST_XOR0: state_d = ST_XOR1;
                ST_XOR1: state_d = ST_XOR2;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        state   = state_q;
        busy    = state_q != ST_IDLE;
        done    = is_last_step(state_q);
        illegal = state_q == ST_ILL;
    end

`ifdef CTRL_RETIRE_CNT_EN
    logic [15:0] retire_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            retire_cnt_q <= 16'h0000;
        else if (done && !illegal)
            retire_cnt_q <= retire_cnt_q + 16'h0001;
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed and random stimulus against an instruction-level model.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        run = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic [3:0]  state;
    logic [15:0] instr_q;
    logic        busy, done, illegal;
`ifdef CTRL_RETIRE_CNT_EN
    logic [15:0] retire_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // instruction-level model: active instruction, its opcode and step index
    logic        m_active = 1'b0;
    logic        m_armed = 1'b0;
    logic [3:0]  m_op = 4'd0;
    int          m_idx = 0;
    logic [15:0] m_instr = 16'h0000;
    logic [15:0] m_cnt = 16'h0000;

    control_sequencer dut (
        .clk        (clk),
        .resetn     (resetn),
        .run        (run),
        .instr      (instr),
        .state      (state),
        .instr_q    (instr_q),
        .busy       (busy),
        .done       (done),
        .illegal    (illegal)
`ifdef CTRL_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic int first_code(input logic [3:0] op);
        case (op)
            4'd0: return 2;
            4'd1: return 3;
            4'd2: return 4;
            4'd3: return 5;
            4'd4: return 6;
            4'd5: return 9;
            4'd6: return 12;
            default: return 1;
        endcase
    endfunction

    function automatic int seq_len(input logic [3:0] op);
        return (op >= 4'd4 && op <= 4'd6) ? 3 : 1;
    endfunction

    function automatic logic m_done();
        return m_active && (m_idx == seq_len(m_op) - 1);
    endfunction

    function automatic logic [3:0] m_state();
        return m_active ? 4'(first_code(m_op) + m_idx) : 4'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("state", 32'(state), 32'(m_state()));
        check("busy", 32'(busy), 32'(m_active));
        check("done", 32'(done), 32'(m_done()));
        check("illegal", 32'(illegal), 32'(m_done() && m_op > 4'd6));
        check("instr_q", 32'(instr_q), 32'(m_instr));
`ifdef CTRL_RETIRE_CNT_EN
        check("retire_cnt", 32'(retire_cnt), 32'(m_cnt));
`endif
    endtask

    task automatic model_edge(input logic r, input logic [15:0] i);
        logic fin;
        fin = m_done();
        if (fin && m_op <= 4'd6) m_cnt++;
        if (m_armed && r && (!m_active || fin)) begin
            m_active = 1'b1;
            m_op = i[15:12];
            m_idx = 0;
            m_instr = i;
        end else if (m_active && !fin) begin
            m_idx++;
        end else begin
            m_active = 1'b0;
        end
        m_armed = 1'b1;
    endtask

    task automatic step(input logic r, input logic [15:0] i);
        run = r;
        instr = i;
        @(posedge clk);
        model_edge(r, i);
        @(negedge clk);
        compare_all();
    endtask

    // asserts reset mid-cycle, checks outputs react without a clock, releases on the next negedge
    task automatic pulse_reset();
        #2 resetn = 1'b0;
        m_active = 1'b0;
        m_armed = 1'b0;
        m_instr = 16'h0000;
        m_cnt = 16'h0000;
        #1 compare_all();
        check("rst_state", 32'(state), 32'h0);
        @(negedge clk);
        compare_all();
        resetn = 1'b1;
    endtask

    initial begin
        pulse_reset();
        step(1'b1, 16'h0120);
        check("no_accept_after_reset", 32'(busy), 32'h0);
        step(1'b1, 16'h0120);
        check("load_state", 32'(state), 32'h2);
        step(1'b0, 16'h0000);
        check("load_idle", 32'(state), 32'h0);

        step(1'b1, 16'h5230);
        check("add0", 32'(state), 32'h9);
        step(1'b0, 16'h0000);
        check("add1", 32'(state), 32'hA);
        step(1'b0, 16'h0000);
        check("add2_done", 32'(done), 32'h1);
        check("add_instr_q", 32'(instr_q), 32'h5230);
        step(1'b0, 16'h0000);

        step(1'b1, 16'h4120);
        step(1'b1, 16'h6340);
        check("sub_held", 32'(instr_q), 32'h4120);
        step(1'b1, 16'h6340);
        check("sub2", 32'(state), 32'h8);
        step(1'b1, 16'h6340);
        check("xor_no_bubble", 32'(state), 32'hC);
        step(1'b0, 16'h0000);
        step(1'b0, 16'h0000);
        step(1'b0, 16'h0000);

        step(1'b1, 16'hA000);
        check("ill_flag", 32'(illegal), 32'h1);
        step(1'b0, 16'h0000);

        step(1'b1, 16'h5230);
        step(1'b0, 16'h0000);
        check("in_add1", 32'(state), 32'hA);
        pulse_reset();
        for (int k = 0; k < 4; k++) step(1'b0, 16'h0000);

        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 3) != 0, 16'($urandom));

        pulse_reset();
        step(1'b0, 16'h0000);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, {4'($urandom_range(4, 6)), 12'($urandom)});
            step(1'b0, 16'h0000);
            step(1'b0, 16'h0000);
            step(1'b0, 16'h0000);
        end

`ifdef CTRL_RETIRE_CNT_EN
        pulse_reset();
        step(1'b0, 16'h0000);
        for (int k = 0; k < 70000 && m_cnt != 16'hFFFF; k++) step(1'b1, 16'h0120);
        check("cnt_preload", 32'(retire_cnt), 32'hFFFF);
        step(1'b0, 16'h0000);
        check("cnt_wrap", 32'(retire_cnt), 32'h0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
